rr_arbiter_8: RTL and testbench

- Registered 8-way round-robin arbiter.
- Sits directly upstream of the 8-to-3 one-hot encoder.
- Collapses an arbitrary 8-bit request vector into a held, strictly one-hot grant that drives the encoder input, so the encoder always sees a legal one-hot word or all-zeros.
- Grants are held until the requester acknowledges, withdraws its request, or a hold timeout expires.

---
 rtl/rr_arbiter_8.sv | 106 ++++++++++
 tb/tb_rr_arbiter_8.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Registered 8-way round-robin arbiter feeding the 8-to-3 one-hot encoder.
// Grants are strictly one-hot and held until ack, request withdrawal, or hold timeout.
module rr_arbiter_8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx;
  logic [IW-1:0]       gidx, gidx_nx;
  logic [CNT_W-1:0]    hold_cnt, hold_nx;
  logic [N-1:0]        grant_nx;
  logic                timeout_nx;

  logic [IW-1:0]       sel;
  logic [IW-1:0]       idx;
  logic                found;
  logic                expire;
  logic                release_now;

  // Rotating priority scan: ptr has highest priority, ptr-1 lowest.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + IW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign expire      = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = ack || !req[gidx] || expire;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    gidx_nx    = gidx;
    hold_nx    = hold_cnt;
    grant_nx   = grant;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        grant_nx = '0;
        if (found) begin
          grant_nx = N'(1) << sel;
          gidx_nx  = sel;
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_nx   = '0;
          ptr_nx     = gidx + 1'b1;
          state_nx   = IDLE;
          // Only a pure expiry is reported; ack or withdrawal take precedence.
          timeout_nx = !ack && req[gidx] && expire;
        end else if (MAX_HOLD != 0) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gidx     <= gidx_nx;
      hold_cnt <= hold_nx;
      grant    <= grant_nx;
      timeout  <= timeout_nx;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: stimulus queues hand-computed expectations,
// a monitor pops and checks them one cycle later.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ack = 1'b0;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int tests  = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] g;
    logic       to;
    string      nm;
  } exp_t;

  exp_t q[$];

  rr_arbiter_8 #(.N(8), .MAX_HOLD(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Monitor: outputs settle after the edge; compare against queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (grant !== e.g) begin
          fails++;
          $display("FAIL %s grant: got %02h expected %02h", e.nm, grant, e.g);
        end
        tests++;
        if (busy !== (e.g != 8'h00)) begin
          fails++;
          $display("FAIL %s busy: got %b expected %b", e.nm, busy, (e.g != 8'h00));
        end
        tests++;
        if (timeout !== e.to) begin
          fails++;
          $display("FAIL %s timeout: got %b expected %b", e.nm, timeout, e.to);
        end
        tests++;
        if (!$onehot0(grant)) begin
          fails++;
          $display("FAIL %s onehot: got %02h expected one-hot or zero", e.nm, grant);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [7:0] rq, input logic a,
                     input logic [7:0] eg, input logic et, input string nm);
    rst = r;
    req = rq;
    ack = a;
    q.push_back('{eg, et, nm});
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset and idle
    cyc(1, 8'h00, 0, 8'h00, 0, "reset");
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 8'h00, 0, "idle");

    // req=24 from ptr 0: bit2 first, then bit5
    cyc(0, 8'h24, 0, 8'h04, 0, "rq24_first");
    cyc(0, 8'h24, 1, 8'h00, 0, "rq24_ack");
    cyc(0, 8'h24, 0, 8'h20, 0, "rq24_second");
    cyc(0, 8'h24, 1, 8'h00, 0, "rq24_ack2");

    // Full rotation from ptr 0
    cyc(1, 8'h00, 0, 8'h00, 0, "reset2");
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'hFF, 0, 8'h01 << i, 0, "rot_grant");
      cyc(0, 8'hFF, 1, 8'h00, 0, "rot_gap");
    end
    cyc(0, 8'hFF, 0, 8'h01, 0, "rot_wrap");
    cyc(0, 8'hFF, 1, 8'h00, 0, "rot_wrap_ack");       // ptr -> 1

    // Hold timeout on lone requester 3
    for (int i = 0; i < 16; i++) cyc(0, 8'h08, 0, 8'h08, 0, "hold");
    cyc(0, 8'h08, 0, 8'h00, 1, "timeout_pulse");      // ptr -> 4
    cyc(0, 8'h08, 0, 8'h08, 0, "regrant_3");
    cyc(0, 8'h00, 0, 8'h00, 0, "withdraw_3");         // ptr -> 4

    // Withdrawal of bit 5, then 41 pending
    cyc(0, 8'h20, 0, 8'h20, 0, "grant_5");
    cyc(0, 8'h41, 0, 8'h00, 0, "withdraw_5");         // ptr -> 6
    cyc(0, 8'h41, 0, 8'h40, 0, "grant_6");
    cyc(0, 8'h41, 1, 8'h00, 0, "ack_6");              // ptr -> 7

    // ack coinciding with expiry suppresses timeout
    cyc(0, 8'h01, 0, 8'h01, 0, "grant_0");
    for (int i = 0; i < 15; i++) cyc(0, 8'h01, 0, 8'h01, 0, "hold_0");
    cyc(0, 8'h01, 1, 8'h00, 0, "ack_at_expiry");      // ptr -> 1

    // Other req bits ignored in GRANT; reset mid-grant
    cyc(0, 8'h10, 0, 8'h10, 0, "grant_4");
    cyc(0, 8'hF0, 0, 8'h10, 0, "hold_4_noise");
    cyc(1, 8'h10, 0, 8'h00, 0, "reset_mid");
    cyc(0, 8'h90, 0, 8'h10, 0, "after_reset_4");
    cyc(0, 8'h90, 1, 8'h00, 0, "ack_4");
    cyc(0, 8'h90, 0, 8'h80, 0, "grant_7");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
